// File: rtl/router_drain_arbiter_pkg.sv
// router_drain_arbiter_pkg: shared state/phase encodings, header field positions and port rotation helper
package router_drain_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, RD, CAP} state_t;
    typedef enum logic [1:0] {HDR, PAY, PAR} phase_t;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/router_drain_arbiter_rr_arb3.sv
// rr_arb3: three-request round-robin arbiter searching from last+1 mod 3
module rr_arb3
    import router_drain_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt,
    output logic [1:0] idx
);
    logic [1:0] c1;
    logic [1:0] c2;
    // First requester after last wins; last itself is only chosen when it is the sole requester.
    always_comb begin
        c1 = next_port(last);
        c2 = next_port(c1);
        idx = req[c1] ? c1 : req[c2] ? c2 : next_port(c2);
        gnt = (|req) ? 3'b001 << idx : 3'b000;
    end
endmodule

// File: rtl/router_drain_arbiter.sv
// router_drain_arbiter: round-robin packet drain from three router FIFOs onto one ready/valid byte stream
module router_drain_arbiter
    import router_drain_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] dout_0,
    input  logic [7:0] dout_1,
    input  logic [7:0] dout_2,
    output logic       rd_en_0,
    output logic       rd_en_1,
    output logic       rd_en_2,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] m_src,
    output logic       par_err,
    output logic       abort,
    output logic       busy
);
    localparam logic [4:0] TMAX = 5'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    phase_t           phase;
    logic [1:0]       grant;
    logic [1:0]       last;
    logic [1:0]       win_idx;
    logic [2:0]       win_gnt;
    logic [2:0]       vld;
    logic [2:0]       rd;
    logic [7:0]       din;
    logic [7:0]       acc;
    logic [LEN_W-1:0] rem;
    logic [4:0]       tcnt;
    logic             can_emit;
    logic             t_inc;
    logic             t_hit;

    assign vld = {vld_out_2, vld_out_1, vld_out_0};
    assign din = (grant == 2'd0) ? dout_0 : (grant == 2'd1) ? dout_1 : dout_2;
    assign can_emit = !m_valid || m_ready;
    assign {rd_en_2, rd_en_1, rd_en_0} = rd;
    assign busy = state != IDLE;

    rr_arb3 u_arb (
        .req  (vld),
        .last (last),
        .gnt  (win_gnt),
        .idx  (win_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state, read strobe and timeout decision; neither reads nor timeout counting happen while a beat is stuck.
    always_comb begin
        state_nxt = state;
        rd = 3'b000;
        t_inc = 1'b0;
        t_hit = 1'b0;
        case (state)
            IDLE: state_nxt = (|win_gnt) ? RD : IDLE;
            RD: begin
                if (vld[grant] && can_emit) begin
                    rd = 3'b001 << grant;
                    state_nxt = CAP;
                end else if (!vld[grant] && can_emit) begin
                    t_inc = 1'b1;
                    t_hit = tcnt == TMAX;
                    state_nxt = t_hit ? IDLE : RD;
                end
            end
            CAP: state_nxt = (phase == PAR) ? IDLE : RD;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant capture, beat load, parity accumulation, length tracking and timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant   <= 2'd0;
            last    <= 2'd2;
            phase   <= HDR;
            rem     <= '0;
            acc     <= '0;
            tcnt    <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            m_src   <= 2'd0;
            par_err <= 1'b0;
            abort   <= 1'b0;
        end else begin
            abort <= t_hit;
            if (m_valid && m_ready) m_valid <= 1'b0;
            if (state == IDLE && |win_gnt) begin
                grant <= win_idx;
                acc   <= '0;
                tcnt  <= '0;
                phase <= HDR;
            end
            if (|rd) tcnt <= '0;
            if (t_inc) tcnt <= tcnt + 5'd1;
            if (t_hit) last <= grant;
            if (state == CAP) begin
                m_data  <= din;
                m_valid <= 1'b1;
                m_sop   <= phase == HDR;
                m_eop   <= phase == PAR;
                m_src   <= grant;
                par_err <= (phase == PAR) && (acc != din);
                case (phase)
                    HDR: begin
                        rem   <= din[LEN_MSB:LEN_LSB];
                        acc   <= din;
                        phase <= (din[LEN_MSB:LEN_LSB] != '0) ? PAY : PAR;
                    end
                    PAY: begin
                        rem   <= rem - LEN_W'(1);
                        acc   <= acc ^ din;
                        phase <= (rem == LEN_W'(1)) ? PAR : PAY;
                    end
                    default: last <= grant;
                endcase
            end
        end
    end
endmodule
